// File: rtl/minx_pkg.sv
// Shared minx bus definitions: CPU bus command codes and the bus arbiter state type.
package minx_pkg;

  localparam logic [1:0] BUS_COMMAND_IDLE      = 2'd0;
  localparam logic [1:0] BUS_COMMAND_IRQ_READ  = 2'd1;
  localparam logic [1:0] BUS_COMMAND_MEM_WRITE = 2'd2;
  localparam logic [1:0] BUS_COMMAND_MEM_READ  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    HANDOFF,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/minx_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  // Scan from farthest to nearest so the closest request to rr_ptr is written last.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if ((req & (NUM_REQ'(1) << ((int'(rr_ptr) + k) % NUM_REQ))) != '0)
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
    end
  end

endmodule

// File: rtl/minx_bus_arbiter.sv
// Round-robin arbiter sharing the s1c88 system bus among DMA-style masters.
// Optional grant hold limit enabled by defining MINX_ARB_TIMEOUT_EN.
module minx_bus_arbiter
  import minx_pkg::*;
#(
  parameter int          NUM_REQ  = 2,
  parameter int          ID_W     = 2,
  parameter logic [15:0] MAX_HOLD = 16'd4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_ce,
  input  logic [NUM_REQ-1:0]    m_req,
  output logic [NUM_REQ-1:0]    m_grant,
  input  logic [24*NUM_REQ-1:0] m_address,
  input  logic [8*NUM_REQ-1:0]  m_data,
  input  logic [NUM_REQ-1:0]    m_read,
  input  logic [NUM_REQ-1:0]    m_write,
  input  logic [2*NUM_REQ-1:0]  m_bus_status,
  output logic                  bus_request,
  input  logic                  bus_ack,
  output logic [23:0]           address_out,
  output logic [7:0]            data_out,
  output logic                  read,
  output logic                  write,
  output logic [1:0]            bus_status,
  output logic [ID_W-1:0]       owner,
  output logic                  owner_valid,
  output logic                  timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || (1 << ID_W) < NUM_REQ || MAX_HOLD == 16'd0) begin : g_bad_cfg
    $error("minx_bus_arbiter: unsupported NUM_REQ/ID_W/MAX_HOLD combination");
  end

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  elig;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                owner_req;
  logic                others_pending;
  logic [ID_W-1:0]     ptr_after_owner;
  logic                tmo_revoke;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (elig),
    .rr_ptr (rr_ptr),
    .winner (pick_id),
    .any    (pick_any)
  );

  assign pick_onehot     = NUM_REQ'(1) << pick_id;
  assign owner_req       = |(m_req & m_grant);
  assign others_pending  = |(elig & ~m_grant);
  assign ptr_after_owner = (int'(owner) >= NUM_REQ - 1) ? '0 : owner + 1'b1;

`ifdef MINX_ARB_TIMEOUT_EN
  logic [15:0]        hold_cnt;
  logic [NUM_REQ-1:0] blocked;

  // A master cut off by timeout stays masked until it lowers its request.
  assign elig       = m_req & ~blocked;
  assign tmo_revoke = (state == GRANT) && bus_ack && owner_req && (hold_cnt == MAX_HOLD - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt    <= '0;
      blocked     <= '0;
      timeout_err <= 1'b0;
    end else if (clk_ce) begin
      timeout_err <= tmo_revoke;
      hold_cnt    <= (state == GRANT) ? hold_cnt + 16'd1 : 16'd0;
      blocked     <= (blocked & m_req) | (tmo_revoke ? m_grant : '0);
    end
  end
`else
  assign elig        = m_req;
  assign tmo_revoke  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      m_grant     <= '0;
      bus_request <= 1'b0;
      owner       <= '0;
      owner_valid <= 1'b0;
      rr_ptr      <= '0;
    end else if (clk_ce) begin
      case (state)
        IDLE: begin
          if (|elig) begin
            bus_request <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (!pick_any) begin
            bus_request <= 1'b0;
            state       <= RELEASE;
          end else if (bus_ack) begin
            m_grant     <= pick_onehot;
            owner       <= pick_id;
            owner_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // CPU pulling ack mid-grant is a protocol error: hand the bus straight back.
          if (!bus_ack) begin
            m_grant     <= '0;
            owner_valid <= 1'b0;
            bus_request <= 1'b0;
            state       <= IDLE;
          end else if (!owner_req || tmo_revoke) begin
            m_grant     <= '0;
            owner_valid <= 1'b0;
            rr_ptr      <= ptr_after_owner;
            if (others_pending) begin
              state <= HANDOFF;
            end else begin
              bus_request <= 1'b0;
              state       <= RELEASE;
            end
          end
        end
        HANDOFF: begin
          if (pick_any) begin
            m_grant     <= pick_onehot;
            owner       <= pick_id;
            owner_valid <= 1'b1;
            state       <= GRANT;
          end else begin
            bus_request <= 1'b0;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          if (!bus_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Master-side mux; an empty grant vector leaves the bus idle.
  always_comb begin
    address_out = '0;
    data_out    = '0;
    read        = 1'b0;
    write       = 1'b0;
    bus_status  = BUS_COMMAND_IDLE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m_grant[i]) begin
        address_out = m_address[24*i +: 24];
        data_out    = m_data[8*i +: 8];
        read        = m_read[i];
        write       = m_write[i];
        bus_status  = m_bus_status[2*i +: 2];
      end
    end
  end

endmodule

// File: tb/tb_minx_bus_arbiter.sv
// Self-checking bench for minx_bus_arbiter: directed protocol cases plus randomized request batches.
module tb_minx_bus_arbiter;
  import minx_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clk_ce = 1'b1;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_grant;
  logic [24*N-1:0] m_address = '0;
  logic [8*N-1:0]  m_data = '0;
  logic [N-1:0]    m_read = '0;
  logic [N-1:0]    m_write = '0;
  logic [2*N-1:0]  m_bus_status = '0;
  logic            bus_request;
  logic            bus_ack;
  logic [23:0]     address_out;
  logic [7:0]      data_out;
  logic            read;
  logic            write;
  logic [1:0]      bus_status;
  logic [IDW-1:0]  owner;
  logic            owner_valid;
  logic            timeout_err;

  logic            auto_cpu = 1'b0;
  logic            man_ack = 1'b0;
  logic            cpu_ack = 1'b0;
  logic            mon_en = 1'b0;
  logic            prev_ov = 1'b0;
  int              gap = 0;
  bit              gap_live = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [23:0] addr[N];
  logic [7:0]  dat[N];
  logic        rd[N];
  logic        wr[N];
  logic [1:0]  st[N];
  int          exp_q[$];
  logic [1:0]  cmds[4];

  assign bus_ack = auto_cpu ? cpu_ack : man_ack;

  always #5 clk = ~clk;

  minx_bus_arbiter #(
    .NUM_REQ  (N),
    .ID_W     (IDW),
    .MAX_HOLD (16'd8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_ce       (clk_ce),
    .m_req        (m_req),
    .m_grant      (m_grant),
    .m_address    (m_address),
    .m_data       (m_data),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_bus_status (m_bus_status),
    .bus_request  (bus_request),
    .bus_ack      (bus_ack),
    .address_out  (address_out),
    .data_out     (data_out),
    .read         (read),
    .write        (write),
    .bus_status   (bus_status),
    .owner        (owner),
    .owner_valid  (owner_valid),
    .timeout_err  (timeout_err)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      m_address[24*i +: 24] = addr[i];
      m_data[8*i +: 8]      = dat[i];
      m_read[i]             = rd[i];
      m_write[i]            = wr[i];
      m_bus_status[2*i +: 2] = st[i];
    end
  endtask

  // CPU side: follows bus_request with a random 0..3 tick delay.
  initial begin
    int cpu_cnt;
    cpu_cnt = 0;
    forever begin
      @(negedge clk);
      if (auto_cpu && (bus_request != cpu_ack)) begin
        if (cpu_cnt == 0) begin
          cpu_ack = bus_request;
          cpu_cnt = $urandom_range(0, 3);
        end else begin
          cpu_cnt--;
        end
      end
    end
  end

  // Monitor: every new grant pops the next expected owner from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (owner_valid && !prev_ov) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got owner %0d expected no grant", owner);
          end else begin
            int e;
            e = exp_q.pop_front();
            chk("grant_owner", owner, e);
            chk("grant_onehot", m_grant, 64'(1) << e);
            chk("mux_addr", address_out, addr[e]);
            chk("mux_data", data_out, dat[e]);
            chk("mux_ctrl", {read, write, bus_status}, {rd[e], wr[e], st[e]});
            if (gap_live) chk("handoff_gap", gap, 1);
          end
          gap_live = 1'b0;
        end else if (!owner_valid) begin
          chk("idle_mux", {address_out, data_out, read, write, bus_status},
              {24'h0, 8'h0, 1'b0, 1'b0, BUS_COMMAND_IDLE});
          if (prev_ov && exp_q.size() > 0) begin
            gap_live = 1'b1;
            gap = 0;
          end
          if (gap_live) begin
            gap++;
            chk("handoff_busreq", bus_request, 1);
          end
        end
      end
      prev_ov = owner_valid;
    end
  end

  initial begin
    int model_ptr;
    int last;
    logic [N-1:0] mask;
    int hold[N];
    int cnt[N];
    bit done;
    int n;

    cmds[0] = BUS_COMMAND_IDLE;
    cmds[1] = BUS_COMMAND_IRQ_READ;
    cmds[2] = BUS_COMMAND_MEM_WRITE;
    cmds[3] = BUS_COMMAND_MEM_READ;

    // Reset values
    tick(2);
    chk("rst_grant", m_grant, 0);
    chk("rst_busreq", bus_request, 0);
    chk("rst_owner", {owner_valid, owner}, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_mux", {address_out, data_out, read, write, bus_status},
        {24'h0, 8'h0, 1'b0, 1'b0, BUS_COMMAND_IDLE});
    reset = 1'b1;

    // Single master, clock-enable gating, latency and mux
    addr[0] = 24'hABCDEF; dat[0] = 8'h11; rd[0] = 1'b0; wr[0] = 1'b1; st[0] = BUS_COMMAND_MEM_WRITE;
    addr[1] = 24'h001000; dat[1] = 8'h5A; rd[1] = 1'b1; wr[1] = 1'b0; st[1] = BUS_COMMAND_MEM_READ;
    drive_bus();
    clk_ce = 1'b0;
    m_req = 2'b10;
    tick(2);
    chk("ce_gate", bus_request, 0);
    clk_ce = 1'b1;
    tick(1);
    chk("busreq_latency", bus_request, 1);
    tick(3);
    chk("no_grant_wo_ack", m_grant, 0);
    man_ack = 1'b1;
    tick(1);
    chk("single_grant", m_grant, 2'b10);
    chk("single_owner", {owner_valid, owner}, {1'b1, 2'd1});
    chk("single_addr", address_out, 24'h001000);
    chk("single_data", data_out, 8'h5A);
    chk("single_ctrl", {read, write, bus_status}, {1'b1, 1'b0, BUS_COMMAND_MEM_READ});

    // bus_ack lost mid-grant
    man_ack = 1'b0;
    tick(1);
    chk("ackloss_grant", {m_grant, owner_valid, bus_request}, 0);
    chk("ackloss_tmo", timeout_err, 0);
    tick(1);
    chk("ackloss_rerequest", bus_request, 1);
    m_req = 2'b00;
    tick(1);
    chk("req_abandon", bus_request, 0);
    tick(1);

    // Release phase ignores new requests until IDLE
    m_req = 2'b01;
    tick(1);
    chk("rel_busreq", bus_request, 1);
    man_ack = 1'b1;
    tick(1);
    chk("rel_grant", m_grant, 2'b01);
    tick(1);
    m_req = 2'b00;
    tick(1);
    chk("rel_drop", {bus_request, owner_valid}, 0);
    m_req = 2'b10;
    tick(1);
    chk("rel_hold1", bus_request, 0);
    tick(1);
    chk("rel_hold2", bus_request, 0);
    man_ack = 1'b0;
    tick(1);
    chk("rel_idle", bus_request, 0);
    tick(1);
    chk("rel_rerequest", bus_request, 1);
    man_ack = 1'b1;
    tick(1);
    chk("rel_next_grant", {m_grant, owner}, {2'b10, 2'd1});
    m_req = 2'b00;
    tick(1);
    man_ack = 1'b0;
    tick(2);

    // Fairness with continuous requests, then async reset mid-grant
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      rd[i] = 1'b1; wr[i] = 1'b1; st[i] = BUS_COMMAND_MEM_WRITE;
    end
    drive_bus();
    m_req = 2'b11;
    tick(1);
    man_ack = 1'b1;
    for (int g = 0; g < 8; g++) begin
      int o;
      for (int t = 0; t < 10 && !owner_valid; t++) tick(1);
      chk("fair_valid", owner_valid, 1);
      chk("fair_owner", owner, g % 2);
      o = int'(owner);
      tick(3);
      if (g < 7) begin
        m_req[o] = 1'b0;
        tick(1);
        chk("handoff_dead", {owner_valid, bus_request, bus_status, read, write},
            {1'b0, 1'b1, BUS_COMMAND_IDLE, 1'b0, 1'b0});
        m_req[o] = 1'b1;
        tick(1);
      end
    end
    #2 reset = 1'b0;
    #1;
    chk("async_rst", {m_grant, bus_request, owner_valid, bus_status, address_out},
        {2'b00, 1'b0, 1'b0, BUS_COMMAND_IDLE, 24'h0});
    tick(1);
    m_req = 2'b00;
    man_ack = 1'b0;
    tick(1);
    reset = 1'b1;

`ifdef MINX_ARB_TIMEOUT_EN
    // Hold limit of 8 ticks with a second master waiting
    m_req = 2'b11;
    tick(1);
    man_ack = 1'b1;
    for (int t = 0; t < 10 && !owner_valid; t++) tick(1);
    chk("tmo_first_owner", {owner_valid, owner}, {1'b1, 2'd0});
    n = 0;
    while (owner_valid && n < 50) begin
      n++;
      tick(1);
    end
    chk("tmo_hold_len", n, 8);
    chk("tmo_pulse", timeout_err, 1);
    tick(1);
    chk("tmo_pulse_end", timeout_err, 0);
    chk("tmo_next_owner", {owner_valid, owner}, {1'b1, 2'd1});
    m_req[1] = 1'b0;
    tick(1);
    chk("tmo_blocked", {bus_request, owner_valid}, 0);
    m_req = 2'b00;
    man_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
`endif

    // Randomized batches against the round-robin scoreboard
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    model_ptr = 0;
    auto_cpu = 1'b1;
    mon_en = 1'b1;
    for (int b = 0; b < 40; b++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        addr[i] = 24'($urandom);
        dat[i]  = 8'($urandom);
        rd[i]   = 1'($urandom);
        wr[i]   = 1'($urandom);
        st[i]   = cmds[$urandom_range(0, 3)];
        hold[i] = $urandom_range(1, 5);
        cnt[i]  = 0;
      end
      drive_bus();
      last = model_ptr;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (model_ptr + k) % N;
        if (mask[idx]) begin
          exp_q.push_back(idx);
          last = idx;
        end
      end
      model_ptr = (last + 1) % N;
      m_req = mask;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
        tick(1);
        for (int i = 0; i < N; i++) begin
          if (m_req[i] && m_grant[i]) begin
            cnt[i]++;
            if (cnt[i] >= hold[i]) m_req[i] = 1'b0;
          end
        end
        done = (m_req == '0) && !bus_request && !cpu_ack;
      end
      chk("batch_done", done, 1);
      if (!done) begin
        m_req = '0;
        exp_q.delete();
        tick(20);
      end
    end
    tick(5);
    chk("queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
